// File: rtl/exp_bias_arbiter.sv
// -----------------------------------------------------------------------------
// exp_bias_arbiter
//
// Purpose:
//   Shares one exponent-unbias unit between NUM_REQ requesters. The arbiter
//   picks one valid requester per cycle. It computes (BIAS - exponent) modulo
//   2^EW and places the result in a single-entry output register.
//
// Arbitration scheme (compile-time macro ARB_ROUND_ROBIN_EN):
//   defined   : round robin. The search starts at a pointer. After a transfer
//               from requester i, the pointer moves to (i+1) mod NUM_REQ.
//   undefined : fixed priority. The lowest valid index wins. No pointer exists.
//
// Ports:
//   clk        in   sole clock; all state updates on the rising edge
//   reset      in   synchronous active-high reset
//   req_valid  in   [NUM_REQ]     per-requester operand valid
//   req_exp    in   [NUM_REQ*EW]  packed exponents, requester i at [i*EW +: EW]
//   req_ready  out  [NUM_REQ]     one-hot-or-zero accept strobe
//   res_valid  out  1             output register holds a result
//   res_data   out  [EW]          BIAS - exponent, modulo 2^EW
//   res_id     out  [IDW]         index of the requester behind res_data
//   res_ready  in   1             downstream accepts the result
//   op_count   out  [8]           accepted-request counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
module exp_bias_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int EW      = 6,
  parameter int BIAS    = 15,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*EW-1:0] req_exp,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  res_valid,
  output logic [EW-1:0]         res_data,
  output logic [IDW-1:0]        res_id,
  input  logic                  res_ready,
  output logic [7:0]            op_count
);

  localparam logic [0:0]    ST_EMPTY = 1'b0;
  localparam logic [0:0]    ST_FULL  = 1'b1;
  localparam logic [EW-1:0] BIAS_W   = EW'(BIAS);

  logic [0:0]     state_q, state_d;
  logic [EW-1:0]  res_data_q, res_data_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic [7:0]     op_count_q, op_count_d;

  logic [EW-1:0]  exp_arr [NUM_REQ];
  logic [IDW-1:0] win_idx;
  logic           any_valid;
  logic           can_accept;
  logic           transfer;

  // Unpack the exponent bus so the winner can be selected by index.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign exp_arr[gi] = req_exp[gi*EW +: EW];
    end
  endgenerate

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr_q, ptr_d;
`endif

  // Winner search: the first valid requester at or after the base index,
  // with wrap. In the fixed-priority build the base is always 0.
  always_comb begin
    int base;
    int cand;
    win_idx   = '0;
    any_valid = 1'b0;
    cand      = 0;
`ifdef ARB_ROUND_ROBIN_EN
    base = int'(ptr_q);
`else
    base = 0;
`endif
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = base + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        win_idx   = IDW'(cand);
      end
    end
  end

  // A result leaving in this cycle frees the register for a new one.
  assign can_accept = (state_q == ST_EMPTY) || res_ready;
  assign transfer   = !reset && can_accept && any_valid;

  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    op_count_d = op_count_q;
    if (transfer) begin
      state_d    = ST_FULL;
      res_data_d = BIAS_W - exp_arr[win_idx];
      res_id_d   = win_idx;
      op_count_d = op_count_q + 8'd1;
    end else if (state_q == ST_FULL && res_ready) begin
      state_d = ST_EMPTY;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    ptr_d = ptr_q;
    if (transfer) begin
      ptr_d = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      res_data_q <= '0;
      res_id_q   <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
      op_count_q <= op_count_d;
    end
  end

  assign res_valid = (state_q == ST_FULL);
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_exp_bias_arbiter.sv
// -----------------------------------------------------------------------------
// tb_exp_bias_arbiter
//
// Directed self-checking bench for exp_bias_arbiter with default parameters
// (NUM_REQ=4, EW=6, BIAS=15). Expected values are hand-computed. Where the
// arbitration scheme changes the answer, the expectation follows
// ARB_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
module tb_exp_bias_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [23:0] req_exp;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [5:0]  res_data;
  logic [1:0]  res_id;
  logic        res_ready;
  logic [7:0]  op_count;

  int errors = 0;
  int checks = 0;

  exp_bias_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_exp   (req_exp),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input int idx, input logic [5:0] v);
    req_exp[idx*6 +: 6] = v;
  endtask

  logic [5:0] bnd_exp [4];
  logic [5:0] bnd_res [4];
  logic [1:0] held_id;
  logic [5:0] held_data;
  logic [1:0] exp_id;

  initial begin
    bnd_exp[0] = 6'd0;  bnd_res[0] = 6'd15;
    bnd_exp[1] = 6'd15; bnd_res[1] = 6'd0;
    bnd_exp[2] = 6'd16; bnd_res[2] = 6'h3F;
    bnd_exp[3] = 6'd63; bnd_res[3] = 6'd16;

    // Reset with all requesters valid: nothing may be granted.
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_exp   = '0;
    res_ready = 1'b0;
    step();
    step();
    check_val("rst_req_ready", 32'(req_ready), 32'h0);
    check_val("rst_res_valid", 32'(res_valid), 32'h0);
    check_val("rst_res_data",  32'(res_data),  32'h0);
    check_val("rst_res_id",    32'(res_id),    32'h0);
    check_val("rst_op_count",  32'(op_count),  32'h0);

    // Single request: exp 20 -> 15-20 = -5 = 6'h3B.
    reset     = 1'b0;
    req_valid = 4'b0001;
    set_exp(0, 6'd20);
    res_ready = 1'b1;
    #1;
    check_val("single_req_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0000;
    check_val("single_res_valid", 32'(res_valid), 32'h1);
    check_val("single_res_data",  32'(res_data),  32'h3B);
    check_val("single_res_id",    32'(res_id),    32'h0);
    check_val("single_op_count",  32'(op_count),  32'h1);
    step();
    check_val("drain_res_valid",  32'(res_valid), 32'h0);

    // Boundary exponents through requester 2, loaded back to back.
    req_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      set_exp(2, bnd_exp[k]);
      step();
      check_val("bnd_res_data", 32'(res_data), 32'(bnd_res[k]));
      check_val("bnd_res_id",   32'(res_id),   32'h2);
    end
    req_valid = 4'b0000;
    step();
    check_val("bnd_op_count", 32'(op_count), 32'h5);

    // Reset so the round-robin pointer starts from 0 for contention.
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Contention: exponent of requester i is i+1 -> result 14-i.
    for (int i = 0; i < 4; i++) set_exp(i, 6'(i + 1));
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_id = 2'(k % 4);
`else
      exp_id = 2'd0;
`endif
      step();
      check_val("cont_res_id",   32'(res_id),   32'(exp_id));
      check_val("cont_res_data", 32'(res_data), 32'(6'd14 - 6'(exp_id)));
    end
    check_val("cont_op_count", 32'(op_count), 32'h5);

    // Backpressure: the result is held (id 0, data 14) while res_ready=0.
    held_id   = 2'd0;
    held_data = 6'd14;
    res_ready = 1'b0;
    req_valid = 4'b0110;
    set_exp(1, 6'd5);
    set_exp(2, 6'd9);
    #1;
    check_val("bp_req_ready0", 32'(req_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("bp_req_ready", 32'(req_ready), 32'h0);
      check_val("bp_res_valid", 32'(res_valid), 32'h1);
      check_val("bp_res_id",    32'(res_id),    32'(held_id));
      check_val("bp_res_data",  32'(res_data),  32'(held_data));
    end
    res_ready = 1'b1;
    #1;
    check_val("bp_release_ready", 32'(req_ready), 32'h2);
    step();
    check_val("bp_load1_valid", 32'(res_valid), 32'h1);
    check_val("bp_load1_id",    32'(res_id),    32'h1);
    check_val("bp_load1_data",  32'(res_data),  32'd10);
    step();
`ifdef ARB_ROUND_ROBIN_EN
    exp_id = 2'd2;
`else
    exp_id = 2'd1;
`endif
    check_val("bp_load2_valid", 32'(res_valid), 32'h1);
    check_val("bp_load2_id",    32'(res_id),    32'(exp_id));
    check_val("bp_load2_data",  32'(res_data),  32'(exp_id == 2'd2 ? 6'd6 : 6'd10));
    check_val("bp_op_count",    32'(op_count),  32'h7);

    // Reset during a stall discards the held result.
    res_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("rs_res_valid", 32'(res_valid), 32'h0);
    check_val("rs_op_count",  32'(op_count),  32'h0);
    check_val("rs_res_data",  32'(res_data),  32'h0);
    req_valid = 4'b1111;
    res_ready = 1'b1;
    #1;
    check_val("rs_req_ready", 32'(req_ready), 32'h1);
    step();
    check_val("rs_res_id",    32'(res_id),    32'h0);
    check_val("rs_op_count1", 32'(op_count),  32'h1);

    // Counter wrap: 255 more transfers -> 256 total -> 0.
    req_valid = 4'b0001;
    for (int k = 1; k <= 255; k++) begin
      step();
      if (k == 254) check_val("wrap_op_count255", 32'(op_count), 32'd255);
    end
    check_val("wrap_op_count0", 32'(op_count), 32'h0);
    req_valid = 4'b0000;
    step();
    check_val("final_res_valid", 32'(res_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
